input_conditioner: RTL and testbench

Front-end conditioner for the board's 18 slide switches and three pushbuttons (KEY1–KEY3), sitting directly upstream of the IO unit. Each raw input is synchronised into the clock domain, debounced and presented as a clean level. Key presses also produce single-cycle pulses and sticky pending flags. A request/acknowledge handshake lets the control path stall an In instruction until the operator confirms with KEY1; the IO unit then reads a switch snapshot captured at that moment.

---
 rtl/input_conditioner.sv | 124 ++++++++++++
 tb/tb_input_conditioner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Switch/pushbutton front end: two-flop synchronisers, per-input debouncers,
// key press strobes with sticky flags, and the In-instruction operator handshake.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] sw_raw,
  input  logic [2:0]  key_raw,
  output logic [17:0] sw_clean,
  output logic [2:0]  key_level,
  output logic [2:0]  key_pulse,
  output logic [2:0]  key_pending,
  input  logic [2:0]  pending_clr,
  // Handshake: io_req is a level held by the control path while an In
  // instruction waits; io_ack is a one-cycle strobe, io_data is valid from
  // that cycle on and holds until the next capture.
  input  logic        io_req,
  output logic        io_ack,
  output logic [31:0] io_data,
  output logic [1:0]  dbg_state
);

  localparam int              N_IN     = 21;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    ACK      = 2'd2,
    WAIT_REL = 2'd3
  } hs_state_e;

  // Bit layout of the input vectors: [17:0] switches, [20:18] keys (active-high).
  logic [N_IN-1:0]  s1_q, s2_q, stable_q;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [2:0]       key_level_dly_q;
  logic [2:0]       pending_q;
  logic [31:0]      data_q;
  hs_state_e        state_q, state_d;
  logic             capture;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= {~key_raw, sw_raw};
      s2_q <= s1_q;
    end
  end

  // Any return to the stable value restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_q <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (s2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= s2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_clean  = stable_q[17:0];
  assign key_level = stable_q[20:18];
  assign key_pulse = key_level & ~key_level_dly_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_level_dly_q <= '0;
      pending_q       <= '0;
    end else begin
      key_level_dly_q <= key_level;
      pending_q       <= (pending_q & ~pending_clr) | key_pulse;
    end
  end

  assign key_pending = pending_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Only a fresh KEY1 strobe counts, so a key held before io_req rose is ignored.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE:     if (io_req) state_d = WAIT_KEY;
      WAIT_KEY: begin
        if (!io_req) begin
          state_d = IDLE;
        end else if (key_pulse[0]) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_REL;
      WAIT_REL: if (!io_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)       data_q <= '0;
    else if (capture) data_q <= {{15{stable_q[17]}}, stable_q[16:0]};
  end

  assign io_ack    = (state_q == ACK);
  assign io_data   = data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random traffic, all
// outputs compared every cycle against a window-based behavioural model.
module tb_input_conditioner;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [17:0] sw_raw;
  logic [2:0]  key_raw;
  logic [17:0] sw_clean;
  logic [2:0]  key_level, key_pulse, key_pending, pending_clr;
  logic        io_req, io_ack;
  logic [31:0] io_data;
  logic [1:0]  dbg_state;

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .key_raw(key_raw),
    .sw_clean(sw_clean), .key_level(key_level), .key_pulse(key_pulse),
    .key_pending(key_pending), .pending_clr(pending_clr), .io_req(io_req),
    .io_ack(io_ack), .io_data(io_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0;
  int pulse1_cnt = 0;
  logic chk_en = 1'b0;
  logic found;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // A bit's clean level flips once its last D synchronised samples all
  // disagree with it; the synchronised sample is raw delayed by two edges.
  logic [20:0] hist_q[$];
  logic [31:0] exp_q[$];
  logic [20:0] m_stable;
  logic [2:0]  m_level_prev, m_pending, m_pulse;
  logic [31:0] m_data;
  logic        m_waiting, m_ack_now, m_need_rel, m_flip;

  always @(posedge clk) begin
    if (!reset) begin
      hist_q.delete();
      for (int i = 0; i < D + 2; i++) hist_q.push_back('0);
      exp_q.delete();
      m_stable = '0; m_level_prev = '0; m_pending = '0; m_data = '0;
      m_waiting = 1'b0; m_ack_now = 1'b0; m_need_rel = 1'b0;
    end else begin
      m_pulse = m_stable[20:18] & ~m_level_prev;
      if (m_ack_now) begin
        m_ack_now  = 1'b0;
        m_need_rel = 1'b1;
      end else if (m_need_rel) begin
        if (!io_req) m_need_rel = 1'b0;
      end else if (m_waiting) begin
        if (!io_req) begin
          m_waiting = 1'b0;
        end else if (m_pulse[0]) begin
          m_data = {{15{m_stable[17]}}, m_stable[16:0]};
          exp_q.push_back(m_data);
          m_waiting = 1'b0;
          m_ack_now = 1'b1;
        end
      end else if (io_req) begin
        m_waiting = 1'b1;
      end
      m_pending    = (m_pending & ~pending_clr) | m_pulse;
      m_level_prev = m_stable[20:18];
      hist_q.push_front({~key_raw, sw_raw});
      void'(hist_q.pop_back());
      for (int b = 0; b < 21; b++) begin
        m_flip = 1'b1;
        for (int k = 2; k < D + 2; k++)
          if (hist_q[k][b] == m_stable[b]) m_flip = 1'b0;
        if (m_flip) m_stable[b] = ~m_stable[b];
      end
    end
    if (io_ack) ack_cnt++;
    if (key_pulse[1]) pulse1_cnt++;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("sw_clean", 32'(sw_clean), 32'(m_stable[17:0]));
      check_eq("key_level", 32'(key_level), 32'(m_stable[20:18]));
      check_eq("key_pulse", 32'(key_pulse), 32'(m_stable[20:18] & ~m_level_prev));
      check_eq("key_pending", 32'(key_pending), 32'(m_pending));
      check_eq("io_ack", 32'(io_ack), 32'(m_ack_now));
      check_eq("io_data", io_data, m_data);
      check_eq("fsm_idle", 32'(dbg_state == 2'd0), 32'(!(m_waiting || m_ack_now || m_need_rel)));
      if (io_ack) begin
        check_eq("ack_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("ack_data", io_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  int a0, p0;
  logic [17:0] sw_tmp;

  initial begin
    reset = 1'b0; sw_raw = 18'h3FFFF; key_raw = 3'b000;
    pending_clr = 3'b0; io_req = 1'b0;

    // Reset with everything asserted
    tick(2);
    chk_en = 1'b1;
    check_eq("rst_sw", 32'(sw_clean), 32'd0);
    check_eq("rst_key", 32'(key_level | key_pulse | key_pending), 32'd0);
    check_eq("rst_io", {io_data[30:0], io_ack}, 32'd0);
    check_eq("rst_idle", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    tick(5);
    check_eq("rel_sw_early", 32'(sw_clean), 32'd0);
    tick(1);
    check_eq("rel_sw_latency", 32'(sw_clean), 32'h3FFFF);
    key_raw = 3'b111; sw_raw = '0;
    tick(12);

    // Bounce rejection on SW3
    sw_raw[3] = 1'b1; tick(2);
    sw_raw[3] = 1'b0; tick(2);
    sw_raw[3] = 1'b1;
    tick(5);
    check_eq("bounce_early", 32'(sw_clean[3]), 32'd0);
    tick(1);
    check_eq("bounce_settle", 32'(sw_clean[3]), 32'd1);

    // Pulse / pending on KEY2
    pending_clr = 3'b111; tick(1); pending_clr = 3'b0;
    check_eq("pend_clr_all", 32'(key_pending), 32'd0);
    p0 = pulse1_cnt;
    key_raw[1] = 1'b0; tick(20);
    key_raw[1] = 1'b1; tick(10);
    check_eq("pulse1_count", 32'(pulse1_cnt - p0), 32'd1);
    check_eq("pend1_set", 32'(key_pending[1]), 32'd1);
    pending_clr = 3'b010; tick(1); pending_clr = 3'b0;
    check_eq("pend1_clr", 32'(key_pending[1]), 32'd0);
    key_raw[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (key_pulse[1]) found = 1'b1;
    end
    check_eq("pulse1_seen", 32'(found), 32'd1);
    pending_clr = 3'b010; tick(1); pending_clr = 3'b0;
    check_eq("pend1_set_wins", 32'(key_pending[1]), 32'd1);
    key_raw[1] = 1'b1; tick(10);

    // Handshake with KEY1 already held
    sw_raw = 18'h20005; tick(10);
    key_raw[0] = 1'b0; tick(10);
    a0 = ack_cnt;
    io_req = 1'b1; tick(10);
    check_eq("held_no_ack", 32'(ack_cnt - a0), 32'd0);
    key_raw[0] = 1'b1; tick(10);
    check_eq("release_no_ack", 32'(ack_cnt - a0), 32'd0);
    key_raw[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (io_ack) found = 1'b1;
    end
    check_eq("ack_seen", 32'(found), 32'd1);
    check_eq("ack_io_data", io_data, 32'hFFFE0005);
    tick(1);
    check_eq("ack_one_cycle", 32'(io_ack), 32'd0);
    key_raw[0] = 1'b1; tick(10);
    key_raw[0] = 1'b0; tick(10);
    check_eq("no_second_ack", 32'(ack_cnt - a0), 32'd1);
    key_raw[0] = 1'b1; tick(10);
    io_req = 1'b0; tick(2);
    check_eq("drop_idle", 32'(dbg_state), 32'd0);

    // Abort coinciding with a KEY1 strobe
    sw_raw = 18'h00123; tick(10);
    a0 = ack_cnt;
    io_req = 1'b1; key_raw[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (key_pulse[0]) found = 1'b1;
    end
    check_eq("abort_pulse_seen", 32'(found), 32'd1);
    io_req = 1'b0; tick(6);
    check_eq("abort_no_ack", 32'(ack_cnt - a0), 32'd0);
    check_eq("abort_data_held", io_data, 32'hFFFE0005);
    check_eq("abort_idle", 32'(dbg_state), 32'd0);
    key_raw[0] = 1'b1; tick(10);

    // Reset in WAIT_KEY with a press in flight
    a0 = ack_cnt;
    io_req = 1'b1; tick(3);
    key_raw[0] = 1'b0; tick(3);
    reset = 1'b0; io_req = 1'b0; key_raw = 3'b111;
    tick(1);
    check_eq("midrst_ack", 32'(io_ack), 32'd0);
    check_eq("midrst_data", io_data, 32'd0);
    check_eq("midrst_level", 32'(key_level), 32'd0);
    check_eq("midrst_idle", 32'(dbg_state), 32'd0);
    tick(1);
    reset = 1'b1; tick(10);
    check_eq("midrst_no_ack", 32'(ack_cnt - a0), 32'd0);

    // Random traffic, checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        sw_tmp = sw_raw;
        sw_tmp[$urandom_range(0, 17)] ^= 1'b1;
        sw_raw = sw_tmp;
      end
      if ($urandom_range(0, 15) == 0) key_raw = key_raw ^ 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) io_req = ~io_req;
      pending_clr = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b0;
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
    end
    reset = 1'b1; pending_clr = 3'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
